// File: rtl/ball_hit_detect.sv
// ball_hit_detect: accumulates ball/rope and ball/player pixel overlaps per
// frame and evaluates them at start of frame. A rope hit raises a split
// request held until acknowledged; a player hit pulses once and then starts a
// frame-counted invulnerability lockout.
// Optional feature: define HIT_SIDE_EN to track which side of the ball centre
// the player overlap fell on (hitSide); otherwise hitSide is tied to 0.
//
// state   | meaning
// S_PLAY  | no split outstanding; a rope hit latches position and requests a split
// S_SPLIT | splitReq held with stable splitX/Y until splitAck is sampled high
module ball_hit_detect #(
  parameter int BALL_SIZE      = 32,
  parameter int LOCKOUT_FRAMES = 60,
  parameter int MIN_PIXELS     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] ballTopLeftX,
  input  logic [10:0] ballTopLeftY,
  input  logic        ballDR,
  input  logic        ropeDR,
  input  logic        playerDR,
  input  logic        splitAck,
  output logic        splitReq,
  output logic [10:0] splitX,
  output logic [10:0] splitY,
  output logic        ropeRetract,
  output logic        playerHit,
  output logic        lockoutActive,
  output logic [7:0]  hitCount,
  output logic        hitSide
);

  typedef enum logic {S_PLAY, S_SPLIT} state_t;

  localparam logic [15:0] MIN_PX    = 16'(MIN_PIXELS);
  localparam logic [7:0]  LOCK_LOAD = 8'(LOCKOUT_FRAMES);

  state_t      state, state_next;
  logic [15:0] rope_cnt, player_cnt;
  logic [7:0]  lockout;
  logic        rope_ov, player_ov;
  logic        rope_hit, player_hit, player_take;
  logic        latch_split;

  // The SOF-cycle pixel belongs to the new frame, so a reload seeds with it.
  function automatic logic [15:0] count_next(input logic [15:0] cnt,
                                             input logic ov,
                                             input logic sof);
    if (sof)
      return {15'd0, ov};
    if (ov && (cnt != 16'hFFFF))
      return cnt + 16'd1;
    return cnt;
  endfunction

  assign rope_ov     = ballDR & ropeDR;
  assign player_ov   = ballDR & playerDR;
  assign rope_hit    = startOfFrame && (rope_cnt >= MIN_PX);
  assign player_hit  = startOfFrame && (player_cnt >= MIN_PX);
  assign player_take = player_hit && (lockout == 8'd0);

  // Per-frame overlap tallies, evaluated on their pre-SOF values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rope_cnt   <= 16'd0;
      player_cnt <= 16'd0;
    end else begin
      rope_cnt   <= count_next(rope_cnt, rope_ov, startOfFrame);
      player_cnt <= count_next(player_cnt, player_ov, startOfFrame);
    end
  end

  // Split handshake state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_PLAY;
    else
      state <= state_next;
  end

  // Next-state: rope hits while a split is outstanding are not queued.
  always_comb begin
    state_next  = state;
    latch_split = 1'b0;
    case (state)
      S_PLAY: begin
        if (rope_hit) begin
          state_next  = S_SPLIT;
          latch_split = 1'b1;
        end
      end
      S_SPLIT: begin
        if (splitAck)
          state_next = S_PLAY;
      end
    endcase
  end

  assign splitReq = (state == S_SPLIT);

  // Registered pulses, split position latch and player lockout bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      ropeRetract <= 1'b0;
      playerHit   <= 1'b0;
      splitX      <= 11'd0;
      splitY      <= 11'd0;
      lockout     <= 8'd0;
      hitCount    <= 8'd0;
    end else begin
      ropeRetract <= rope_hit;
      playerHit   <= player_take;
      if (latch_split) begin
        splitX <= ballTopLeftX;
        splitY <= ballTopLeftY;
      end
      if (player_take) begin
        lockout <= LOCK_LOAD;
        if (hitCount != 8'hFF)
          hitCount <= hitCount + 8'd1;
      end else if (startOfFrame && (lockout != 8'd0)) begin
        lockout <= lockout - 8'd1;
      end
    end
  end

  assign lockoutActive = (lockout != 8'd0);

`ifdef HIT_SIDE_EN
  logic [15:0] left_cnt, right_cnt;
  logic        on_left;

  assign on_left = ({1'b0, pixelX} < ({1'b0, ballTopLeftX} + 12'(BALL_SIZE / 2)));

  // Player overlap split by side of the ball centre.
  always_ff @(posedge clk) begin
    if (reset) begin
      left_cnt  <= 16'd0;
      right_cnt <= 16'd0;
    end else begin
      left_cnt  <= count_next(left_cnt, player_ov & on_left, startOfFrame);
      right_cnt <= count_next(right_cnt, player_ov & ~on_left, startOfFrame);
    end
  end

  // Side is captured with each accepted player hit and held until the next.
  always_ff @(posedge clk) begin
    if (reset)
      hitSide <= 1'b0;
    else if (player_take)
      hitSide <= (right_cnt > left_cnt);
  end
`else
  logic [10:0] unused_side;
  assign unused_side = pixelX ^ 11'(BALL_SIZE);
  assign hitSide     = 1'b0;
`endif

endmodule

// File: tb/tb_ball_hit_detect.sv
// Bench for ball_hit_detect: frame-level reference model checked every cycle,
// a table of single-frame vectors, hand-written handshake/lockout/SOF-pixel/
// hit-side sequences, then randomized traffic.
module tb_ball_hit_detect;
  localparam int MIN_PX = 4;
  localparam int LOCK   = 60;
  localparam int BSZ    = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1, startOfFrame = 1'b0;
  logic        ballDR = 1'b0, ropeDR = 1'b0, playerDR = 1'b0, splitAck = 1'b0;
  logic [10:0] pixelX = '0, ballTopLeftX = '0, ballTopLeftY = '0;
  logic        splitReq, ropeRetract, playerHit, lockoutActive, hitSide;
  logic [10:0] splitX, splitY;
  logic [7:0]  hitCount;

  int n_vec = 0;
  int n_err = 0;
  bit seen_req = 0;

  always #5 clk = ~clk;

  ball_hit_detect #(.BALL_SIZE(BSZ), .LOCKOUT_FRAMES(LOCK), .MIN_PIXELS(MIN_PX)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .pixelX(pixelX),
    .ballTopLeftX(ballTopLeftX), .ballTopLeftY(ballTopLeftY), .ballDR(ballDR),
    .ropeDR(ropeDR), .playerDR(playerDR), .splitAck(splitAck), .splitReq(splitReq),
    .splitX(splitX), .splitY(splitY), .ropeRetract(ropeRetract), .playerHit(playerHit),
    .lockoutActive(lockoutActive), .hitCount(hitCount), .hitSide(hitSide)
  );

  // Reference model: pixel tallies for the frame in progress, pending split, lockout frames left.
  int m_rope = 0, m_player = 0, m_left = 0, m_right = 0, m_lock = 0, m_hits = 0;
  int m_sx = 0, m_sy = 0;
  bit m_pend = 0, m_rr = 0, m_ph = 0, m_side = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_step();
    bit rope_ov, pl_ov, on_left, rope_hit, pl_hit, was_pend;
    m_rr = 0;
    m_ph = 0;
    if (reset) begin
      m_rope = 0; m_player = 0; m_left = 0; m_right = 0; m_lock = 0; m_hits = 0;
      m_sx = 0; m_sy = 0; m_pend = 0; m_side = 0;
      return;
    end
    rope_ov  = ballDR && ropeDR;
    pl_ov    = ballDR && playerDR;
    on_left  = int'(pixelX) < int'(ballTopLeftX) + BSZ / 2;
    was_pend = m_pend;
    if (was_pend && splitAck) m_pend = 0;
    if (startOfFrame) begin
      rope_hit = (m_rope >= MIN_PX);
      pl_hit   = (m_player >= MIN_PX);
      m_rr     = rope_hit;
      if (rope_hit && !was_pend) begin
        m_pend = 1;
        m_sx   = int'(ballTopLeftX);
        m_sy   = int'(ballTopLeftY);
      end
      if (pl_hit && m_lock == 0) begin
        m_ph   = 1;
        m_hits = (m_hits < 255) ? m_hits + 1 : 255;
        m_lock = LOCK;
        m_side = (m_right > m_left);
      end else if (m_lock > 0) begin
        m_lock--;
      end
      m_rope   = int'(rope_ov);
      m_player = int'(pl_ov);
      m_left   = int'(pl_ov && on_left);
      m_right  = int'(pl_ov && !on_left);
    end else begin
      m_rope   = sat16(m_rope + int'(rope_ov));
      m_player = sat16(m_player + int'(pl_ov));
      m_left   = sat16(m_left + int'(pl_ov && on_left));
      m_right  = sat16(m_right + int'(pl_ov && !on_left));
    end
  endtask

  task automatic compare_all();
    chk("splitReq", splitReq, m_pend);
    chk("splitX", splitX, m_sx);
    chk("splitY", splitY, m_sy);
    chk("ropeRetract", ropeRetract, m_rr);
    chk("playerHit", playerHit, m_ph);
    chk("lockoutActive", lockoutActive, m_lock != 0);
    chk("hitCount", hitCount, m_hits);
`ifdef HIT_SIDE_EN
    chk("hitSide", hitSide, m_side);
`else
    chk("hitSide", hitSide, 0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    if (splitReq === 1'b1) seen_req = 1;
  endtask

  task automatic do_reset();
    reset = 1; startOfFrame = 0; ballDR = 0; ropeDR = 0; playerDR = 0; splitAck = 0;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic pix(int n, bit r, bit p, int px0);
    for (int i = 0; i < n; i++) begin
      ballDR = 1; ropeDR = r; playerDR = p; pixelX = 11'(px0 + i);
      tick();
    end
    ballDR = 0; ropeDR = 0; playerDR = 0;
  endtask

  task automatic sof_tick(bit b, bit r, bit p);
    startOfFrame = 1; ballDR = b; ropeDR = r; playerDR = p;
    tick();
    startOfFrame = 0; ballDR = 0; ropeDR = 0; playerDR = 0;
  endtask

  task automatic side_case(int x0, int n, bit exp_side);
    do_reset();
    ballTopLeftX = 11'd300;
    pix(n, 0, 1, x0);
    sof_tick(0, 0, 0);
    chk("side_ph", playerHit, 1);
`ifdef HIT_SIDE_EN
    chk("side_val", hitSide, exp_side);
`else
    chk("side_val", hitSide, 0);
`endif
  endtask

  typedef struct {
    int n_rope;
    int n_player;
    bit exp_rr;
    bit exp_ph;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{3, 0, 1'b0, 1'b0};
    tbl[1] = '{4, 0, 1'b1, 1'b0};
    tbl[2] = '{0, 3, 1'b0, 1'b0};
    tbl[3] = '{0, 4, 1'b0, 1'b1};
    tbl[4] = '{5, 6, 1'b1, 1'b1};
    tbl[5] = '{0, 0, 1'b0, 1'b0};
    tbl[6] = '{4, 3, 1'b1, 1'b0};
    tbl[7] = '{10, 10, 1'b1, 1'b1};

    // Reset values
    do_reset();
    chk("rst_splitReq", splitReq, 0);
    chk("rst_hitCount", hitCount, 0);
    chk("rst_lockout", lockoutActive, 0);

    // Idle frames: nothing ever rises
    seen_req = 0;
    for (int f = 0; f < 3; f++) begin
      sof_tick(0, 0, 0);
      chk("idle_rr", ropeRetract, 0);
      chk("idle_ph", playerHit, 0);
      repeat (9) tick();
    end
    chk("idle_no_split", seen_req, 0);

    // Single-frame table (MIN_PIXELS threshold)
    for (int i = 0; i < 8; i++) begin
      do_reset();
      pix(tbl[i].n_rope, 1, 0, 0);
      pix(tbl[i].n_player, 0, 1, 0);
      sof_tick(0, 0, 0);
      chk("tbl_rr", ropeRetract, tbl[i].exp_rr);
      chk("tbl_ph", playerHit, tbl[i].exp_ph);
      chk("tbl_sreq", splitReq, tbl[i].exp_rr);
      chk("tbl_lock", lockoutActive, tbl[i].exp_ph);
    end

    // Split handshake with delayed ack; later rope hit neither re-latches nor queues
    do_reset();
    ballTopLeftX = 11'd100; ballTopLeftY = 11'd200;
    pix(5, 1, 0, 50);
    sof_tick(0, 0, 0);
    chk("split_rr", ropeRetract, 1);
    chk("split_rise", splitReq, 1);
    ballTopLeftX = 11'd7; ballTopLeftY = 11'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("split_hold_req", splitReq, 1);
      chk("split_hold_x", splitX, 100);
      chk("split_hold_y", splitY, 200);
    end
    chk("split_rr_once", ropeRetract, 0);
    pix(5, 1, 0, 50);
    sof_tick(0, 0, 0);
    chk("split_rr_again", ropeRetract, 1);
    chk("split_no_relatch", splitX, 100);
    splitAck = 1;
    tick();
    splitAck = 0;
    chk("split_drop", splitReq, 0);
    sof_tick(0, 0, 0);
    tick();
    chk("split_not_queued", splitReq, 0);

    // Ack present in the cycle the request first rises
    do_reset();
    pix(4, 1, 0, 0);
    splitAck = 1;
    sof_tick(0, 0, 0);
    chk("ack_same_rise", splitReq, 1);
    tick();
    chk("ack_same_drop", splitReq, 0);
    splitAck = 0;

    // Reset in the middle of a handshake
    pix(4, 1, 0, 0);
    sof_tick(0, 0, 0);
    chk("midrst_req_up", splitReq, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("midrst_req", splitReq, 0);
    chk("midrst_x", splitX, 0);
    tick();
    chk("midrst_stay", splitReq, 0);

    // Lockout: player overlap every frame for 70 frames
    do_reset();
    pix(4, 0, 1, 0);
    for (int k = 1; k <= 70; k++) begin
      sof_tick(0, 0, 0);
      chk("lock_ph", playerHit, (k == 1 || k == 62));
      chk("lock_active", lockoutActive, (k <= 60 || k >= 62));
      pix(4, 0, 1, 0);
      tick();
    end
    chk("lock_hitcount", hitCount, 2);

    // SOF-cycle pixel belongs to the new frame; simultaneous hits
    do_reset();
    pix(4, 1, 1, 0);
    sof_tick(1, 1, 1);
    chk("both_rr", ropeRetract, 1);
    chk("both_ph", playerHit, 1);
    pix(3, 1, 1, 0);
    sof_tick(0, 0, 0);
    chk("sofpix_counts", ropeRetract, 1);
    pix(3, 1, 0, 0);
    sof_tick(1, 1, 0);
    chk("sofpix_excluded", ropeRetract, 0);
    pix(3, 1, 0, 0);
    sof_tick(0, 0, 0);
    chk("sofpix_next", ropeRetract, 1);

    // Hit side around centre X = 316
    side_case(320, 6, 1);
    pix(6, 0, 1, 290);
    sof_tick(0, 0, 0);
`ifdef HIT_SIDE_EN
    chk("side_hold", hitSide, 1);
`else
    chk("side_hold", hitSide, 0);
`endif
    side_case(310, 6, 0);
    side_case(313, 6, 0);
    side_case(314, 6, 1);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset        = ($urandom_range(0, 499) == 0);
      startOfFrame = ($urandom_range(0, 11) == 0);
      ballDR       = ($urandom_range(0, 1) == 0);
      ropeDR       = ($urandom_range(0, 3) == 0);
      playerDR     = ($urandom_range(0, 2) == 0);
      splitAck     = ($urandom_range(0, 7) == 0);
      pixelX       = 11'($urandom_range(280, 360));
      ballTopLeftX = 11'($urandom_range(280, 320));
      ballTopLeftY = 11'($urandom_range(0, 2047));
      tick();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ball_hit_detect.md
Name: ball_hit_detect

Overview:
- Consumer of the ball trajectory generator's top-left position and of the per-pixel draw-request stream.
- Accumulates ball/rope and ball/player pixel overlaps over each frame and evaluates them at start of frame.
- Rope hit: issues a held split request, handshaked with the ball generator/spawner.
- Player hit: issues a one-cycle pulse followed by a frame-counted invulnerability lockout.

Parameters:
- BALL_SIZE, 32, ball bitmap width/height in pixels; used for the centre computation (optional feature).
- LOCKOUT_FRAMES, 60, number of frames after a player hit during which further player hits are suppressed.
- MIN_PIXELS, 1, minimum overlap pixels in one frame to count as a hit (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at each frame start (30 Hz).
- pixelX  in  11  current pixel X.
- ballTopLeftX  in  11  ball top-left X from the trajectory block.
- ballTopLeftY  in  11  ball top-left Y from the trajectory block.
- ballDR  in  1  ball drawing request for the current pixel.
- ropeDR  in  1  rope drawing request for the current pixel.
- playerDR  in  1  player drawing request for the current pixel.
- splitAck  in  1  consumer accepted the split request.
- splitReq  out  1  ball split request; held until acknowledged.
- splitX  out  11  latched ball X at the split.
- splitY  out  11  latched ball Y at the split.
- ropeRetract  out  1  one-cycle pulse: rope hit the ball.
- playerHit  out  1  one-cycle pulse: ball hit the player, outside lockout.
- lockoutActive  out  1  high while the lockout counter is non-zero.
- hitCount  out  8  player hits taken; saturates at 255.
- hitSide  out  1  0 = hit pixels mostly left of ball centre, 1 = mostly right.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - FSM in S_PLAY.
  - Overlap counters and lockout counter cleared.
  - Reset mid-handshake drops splitReq in the next cycle; no pending state survives.
- Overlap counters:
  - ropeCnt and playerCnt, 16 bits, saturating at 65535.
  - Each cycle: ropeCnt increments if ballDR && ropeDR; playerCnt increments if ballDR && playerDR.
- On startOfFrame:
  - Evaluate ropeHitF = ropeCnt >= MIN_PIXELS and playerHitF = playerCnt >= MIN_PIXELS, using the pre-pulse counter values.
  - Reload each counter with 1 if its overlap is true in that same cycle, else 0. The SOF-cycle pixel belongs to the new frame.
- Output latency: all outputs are registered and assert in the cycle after the startOfFrame cycle.
- FSM, S_PLAY:
  - If ropeHitF: pulse ropeRetract, latch splitX/Y from ballTopLeftX/Y, set splitReq, go to S_SPLIT.
  - splitAck is ignored in S_PLAY.
- FSM, S_SPLIT:
  - splitReq stays high; splitX/Y stay stable.
  - splitAck sampled high → splitReq low next cycle, return to S_PLAY.
  - splitAck high in the same cycle splitReq first rises counts as an acknowledge.
  - Rope hits evaluated while in S_SPLIT still pulse ropeRetract but are neither queued nor re-latched.
- Lockout counter, 8 bits, independent of the FSM:
  - At SOF: if playerHitF && lockout == 0, pulse playerHit, increment hitCount (saturating), load lockout = LOCKOUT_FRAMES.
  - Otherwise, if lockout != 0, decrement it.
  - lockoutActive = (lockout != 0), registered.
- Simultaneous rope and player hits in one frame: both are processed in the same cycle.
- ballTopLeftX/Y are sampled only at the SOF cycle of a rope hit.

Optional Feature:
- Macro HIT_SIDE_EN.
- Defined:
  - Two more 16-bit saturating counters, leftCnt and rightCnt, count player-overlap pixels by side of the ball centre.
  - Left side: pixelX < ballTopLeftX + BALL_SIZE/2. Otherwise right side.
  - Both counters clear at SOF, with the same reload rule as the other overlap counters.
  - hitSide is registered with playerHit as (rightCnt > leftCnt); a tie gives 0.
  - hitSide holds its value until the next playerHit.
- Not defined: counters are absent and hitSide is tied to 0.

Test Plan:
- Reset, 3 frames, no DR activity → all outputs 0; splitReq never rises.
- Rope/ball overlap of 5 pixels in frame N, ballTopLeft = (100,200), splitAck held 0 for 10 cycles then pulsed → ropeRetract pulses 1 cycle after SOF N+1; splitReq stays high and splitX/Y stay 100/200 until the cycle after splitAck, then drop.
- Player overlap in every frame for 70 frames, LOCKOUT_FRAMES = 60 → playerHit at frames 1 and 62 only; hitCount = 2; lockoutActive high for 60 frames after each hit.
- MIN_PIXELS = 4, overlaps of 3 pixels then 4 pixels → no hit for the 3-pixel frame; hit for the 4-pixel frame.
- Rope and player overlap in the same frame; overlap pixel asserted exactly on the SOF cycle → both pulses in the same cycle; the SOF pixel counts toward the next frame.
- HIT_SIDE_EN defined, BALL_SIZE = 32, ballTopLeftX = 300, player pixels at X = 320..325 → hitSide = 1. Without the macro → hitSide = 0.
